// File: rtl/sccb_write_arbiter_if.sv
// Handshake bundle between two register-write requesters, the arbiter and the SCCB master.
// The slave modport is the arbiter's view; the master modport is the requester/SCCB side.
interface sccb_write_arbiter_if;
  localparam int unsigned BYTE_W = 8;

  logic              req0;
  logic [BYTE_W-1:0] addr0;
  logic [BYTE_W-1:0] data0;
  logic              ack0;
  logic              req1;
  logic [BYTE_W-1:0] addr1;
  logic [BYTE_W-1:0] data1;
  logic              ack1;
  logic              sccb_ready;
  logic              sccb_start;
  logic [BYTE_W-1:0] sccb_addr;
  logic [BYTE_W-1:0] sccb_data;
  logic              busy;
  logic              owner;

  modport slave (
    input  req0, addr0, data0, req1, addr1, data1, sccb_ready,
    output ack0, ack1, sccb_start, sccb_addr, sccb_data, busy, owner
  );

  modport master (
    output req0, addr0, data0, req1, addr1, data1, sccb_ready,
    input  ack0, ack1, sccb_start, sccb_addr, sccb_data, busy, owner
  );
endinterface

// File: rtl/sccb_write_arbiter.sv
// Serialises register writes from two requesters onto one SCCB master, with a post-write gap
// and a long settle after an OV7670 soft reset. Define SCCB_ARB_RR_EN for round-robin arbitration.
module sccb_write_arbiter #(
  parameter int unsigned CLK_FREQ      = 27000000,
  parameter int unsigned SETTLE_CYCLES = CLK_FREQ / 1000,
  parameter int unsigned GAP_CYCLES    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sccb_write_arbiter_if.slave  bus
);
  localparam int unsigned     BYTE_W          = 8;
  localparam logic [BYTE_W-1:0] SOFT_RESET_ADDR = 8'h12;
  localparam int unsigned     MAX_CYCLES      = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int unsigned     CNT_W           = (MAX_CYCLES > 0) ? $clog2(MAX_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE,
    SETTLE
  } state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] addr;
    logic [BYTE_W-1:0] data;
  } wr_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  wr_t              wr_q, wr_n;
  logic             owner_q, owner_n;
  logic             start_q, start_n;
  logic             ack0_q, ack0_n;
  logic             ack1_q, ack1_n;
  logic             busy_q, busy_n;
  logic             grant1;
  logic             soft_reset;
  logic [CNT_W-1:0] settle_load;
`ifdef SCCB_ARB_RR_EN
  logic             prio1_q, prio1_n;
`endif

  // Port 1 wins when it is the only requester, or when round-robin currently favours it.
`ifdef SCCB_ARB_RR_EN
  assign grant1 = bus.req1 & (~bus.req0 | prio1_q);
`else
  assign grant1 = bus.req1 & ~bus.req0;
`endif

  assign soft_reset  = (wr_q.addr == SOFT_RESET_ADDR) && wr_q.data[BYTE_W-1];
  assign settle_load = soft_reset ? CNT_W'(SETTLE_CYCLES) : CNT_W'(GAP_CYCLES);

  // Next-state and next-output logic.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    wr_n    = wr_q;
    owner_n = owner_q;
    start_n = 1'b0;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
`ifdef SCCB_ARB_RR_EN
    prio1_n = prio1_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.sccb_ready && (bus.req0 || bus.req1)) begin
          owner_n = grant1;
          wr_n    = grant1 ? {bus.addr1, bus.data1} : {bus.addr0, bus.data0};
          state_n = ISSUE;
`ifdef SCCB_ARB_RR_EN
          prio1_n = ~grant1;
`endif
        end
      end
      ISSUE: begin
        start_n = 1'b1;
        state_n = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        if (!bus.sccb_ready) begin
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.sccb_ready) begin
          ack0_n  = ~owner_q;
          ack1_n  = owner_q;
          cnt_n   = settle_load;
          state_n = (settle_load == '0) ? IDLE : SETTLE;
        end
      end
      SETTLE: begin
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      owner_q <= 1'b0;
      start_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SCCB_ARB_RR_EN
      prio1_q <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      wr_q    <= wr_n;
      owner_q <= owner_n;
      start_q <= start_n;
      ack0_q  <= ack0_n;
      ack1_q  <= ack1_n;
      busy_q  <= busy_n;
`ifdef SCCB_ARB_RR_EN
      prio1_q <= prio1_n;
`endif
    end
  end

  assign bus.sccb_start = start_q;
  assign bus.sccb_addr  = wr_q.addr;
  assign bus.sccb_data  = wr_q.data;
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.busy       = busy_q;
  assign bus.owner      = owner_q;
endmodule
